reorder_buffer: RTL and testbench

Circular 16-entry reorder buffer that allocates tags to dispatched instructions, collects ALU results, and retires entries in program order. It is the producer side of the tag/commit protocol consumed by the reservation station and register file. It hands out `next_tag`, answers operand-tag queries at dispatch, broadcasts one commit per cycle on the commit line, and raises `clear` on a branch mispredict.

---
 rtl/reorder_buffer.sv | 154 +++++++++++++++
 tb/tb_reorder_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out tags at dispatch, collects ALU results,
// retires in program order, and flushes everything on a branch mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 5,
    parameter int XLEN     = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             dispatch_rdy,
    input  logic             up_has_rd,
    input  logic             up_is_branch,
    input  logic             up_pred_taken,
    output logic [TAG_W-1:0] next_tag,
    output logic             ROB_FULL,
    input  logic [TAG_W-1:0] query_rs1_tag,
    input  logic [TAG_W-1:0] query_rs2_tag,
    output logic             ROB_rs1_valid,
    output logic             ROB_rs2_valid,
    output logic [XLEN-1:0]  ROB_rs1_ans_output,
    output logic [XLEN-1:0]  ROB_rs2_ans_output,
    input  logic             alu_rdy,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic [XLEN-1:0]  alu_ans,
    input  logic             alu_jump,
    input  logic [XLEN-1:0]  alu_next_pc,
    output logic             ROB_write_reg_rdy,
    output logic [XLEN-1:0]  ROB_write_val,
    output logic [TAG_W-1:0] ROB_head_tag,
    output logic             clear,
    output logic [XLEN-1:0]  clear_pc
);

    localparam logic [TAG_W-1:0] ONE     = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST    = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0] FULL_AT = TAG_W'(ROB_SIZE - 2);

    // Entry 0 exists only so tags index the arrays directly; it is never busy.
    logic [ROB_SIZE:0] busy_q, ready_q, has_rd_q, is_branch_q, pred_q, jump_q;
    logic [XLEN-1:0]   val_q     [0:ROB_SIZE];
    logic [XLEN-1:0]   next_pc_q [0:ROB_SIZE];

    logic [TAG_W-1:0] head_q, tail_q, count_q;
    logic             do_alloc, do_wb, do_commit, mispredict, wb_live;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
        return (p == LAST) ? ONE : p + ONE;
    endfunction

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= LAST);
    endfunction

    // Operand lookup: a same-cycle ALU result wins over the stored value.
    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
        lookup = '0;
        if (tag_ok(t)) begin
            if (wb_live && alu_tag == t)
                lookup = {1'b1, alu_ans};
            else if (busy_q[t] && ready_q[t])
                lookup = {1'b1, val_q[t]};
        end
    endfunction

    // Upstream units flush during the clear cycle, so their requests are stale.
    assign wb_live    = alu_rdy && !clear;
    assign do_alloc   = rdy_in && !clear && dispatch_rdy && (count_q < LAST);
    assign do_wb      = rdy_in && wb_live && tag_ok(alu_tag) && busy_q[alu_tag];
    assign do_commit  = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign mispredict = do_commit && is_branch_q[head_q] && (jump_q[head_q] != pred_q[head_q]);

    assign next_tag = tail_q;
    assign ROB_FULL = (count_q >= FULL_AT);

    always_comb begin
        {ROB_rs1_valid, ROB_rs1_ans_output} = lookup(query_rs1_tag);
        {ROB_rs2_valid, ROB_rs2_ans_output} = lookup(query_rs2_tag);
    end

    // NOTE: sequential state uses non-blocking assignments so every process
    // sees the pre-edge values; later assignments in a block win on conflicts.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= ONE;
            tail_q  <= ONE;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
        end else if (mispredict) begin
            head_q  <= ONE;
            tail_q  <= ONE;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (do_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= wrap_inc(tail_q);
            end
            if (do_wb)
                ready_q[alu_tag] <= 1'b1;
            if (do_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= wrap_inc(head_q);
            end
            case ({do_alloc, do_commit})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage has no reset; it is only ever read behind busy/ready,
    // which are reset, so clearing it would add reset fan-out for nothing.
    always_ff @(posedge clk_in) begin
        if (do_alloc) begin
            has_rd_q[tail_q]    <= up_has_rd;
            is_branch_q[tail_q] <= up_is_branch;
            pred_q[tail_q]      <= up_pred_taken;
        end
        if (do_wb) begin
            val_q[alu_tag]     <= alu_ans;
            jump_q[alu_tag]    <= alu_jump;
            next_pc_q[alu_tag] <= alu_next_pc;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ROB_write_reg_rdy <= 1'b0;
            ROB_write_val     <= '0;
            ROB_head_tag      <= ONE;
            clear             <= 1'b0;
            clear_pc          <= '0;
        end else if (rdy_in) begin
            ROB_write_reg_rdy <= do_commit && has_rd_q[head_q];
            clear             <= mispredict;
            if (do_commit) begin
                ROB_write_val <= val_q[head_q];
                ROB_head_tag  <= wrap_inc(head_q);
            end
            if (mispredict)
                clear_pc <= next_pc_q[head_q];
        end else begin
            ROB_write_reg_rdy <= 1'b0;
            clear             <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: one task per scenario,
// expected values hand-computed from the buffer's allocation/commit rules.
module tb_reorder_buffer;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 5;
    localparam int XLEN     = 32;

    logic             clk_in, rst_in, rdy_in;
    logic             dispatch_rdy, up_has_rd, up_is_branch, up_pred_taken;
    logic [TAG_W-1:0] next_tag;
    logic             ROB_FULL;
    logic [TAG_W-1:0] query_rs1_tag, query_rs2_tag;
    logic             ROB_rs1_valid, ROB_rs2_valid;
    logic [XLEN-1:0]  ROB_rs1_ans_output, ROB_rs2_ans_output;
    logic             alu_rdy, alu_jump;
    logic [TAG_W-1:0] alu_tag;
    logic [XLEN-1:0]  alu_ans, alu_next_pc;
    logic             ROB_write_reg_rdy;
    logic [XLEN-1:0]  ROB_write_val;
    logic [TAG_W-1:0] ROB_head_tag;
    logic             clear;
    logic [XLEN-1:0]  clear_pc;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatch_rdy(dispatch_rdy), .up_has_rd(up_has_rd),
        .up_is_branch(up_is_branch), .up_pred_taken(up_pred_taken),
        .next_tag(next_tag), .ROB_FULL(ROB_FULL),
        .query_rs1_tag(query_rs1_tag), .query_rs2_tag(query_rs2_tag),
        .ROB_rs1_valid(ROB_rs1_valid), .ROB_rs2_valid(ROB_rs2_valid),
        .ROB_rs1_ans_output(ROB_rs1_ans_output), .ROB_rs2_ans_output(ROB_rs2_ans_output),
        .alu_rdy(alu_rdy), .alu_tag(alu_tag), .alu_ans(alu_ans),
        .alu_jump(alu_jump), .alu_next_pc(alu_next_pc),
        .ROB_write_reg_rdy(ROB_write_reg_rdy), .ROB_write_val(ROB_write_val),
        .ROB_head_tag(ROB_head_tag), .clear(clear), .clear_pc(clear_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in        = 1'b1;
        dispatch_rdy  = 1'b0;
        up_has_rd     = 1'b0;
        up_is_branch  = 1'b0;
        up_pred_taken = 1'b0;
        query_rs1_tag = '0;
        query_rs2_tag = '0;
        alu_rdy       = 1'b0;
        alu_tag       = '0;
        alu_ans       = '0;
        alu_jump      = 1'b0;
        alu_next_pc   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic dispatch(input logic has_rd, input logic br, input logic pred);
        dispatch_rdy  = 1'b1;
        up_has_rd     = has_rd;
        up_is_branch  = br;
        up_pred_taken = pred;
        step();
        dispatch_rdy  = 1'b0;
    endtask

    task automatic set_alu(input int tag, input logic [XLEN-1:0] ans,
                           input logic jump, input logic [XLEN-1:0] npc);
        alu_rdy     = 1'b1;
        alu_tag     = TAG_W'(tag);
        alu_ans     = ans;
        alu_jump    = jump;
        alu_next_pc = npc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (next_tag !== 5'd1) begin errors++; $display("FAIL reset_next_tag got %0d exp 1", next_tag); end
        checks++; if (ROB_head_tag !== 5'd1) begin errors++; $display("FAIL reset_head_tag got %0d exp 1", ROB_head_tag); end
        checks++; if (ROB_FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", ROB_FULL); end
        checks++; if (ROB_write_reg_rdy !== 1'b0) begin errors++; $display("FAIL reset_wr_rdy got %0b exp 0", ROB_write_reg_rdy); end
        checks++; if (ROB_write_val !== 32'h0) begin errors++; $display("FAIL reset_wr_val got %0h exp 0", ROB_write_val); end
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %0b exp 0", clear); end
        checks++; if (clear_pc !== 32'h0) begin errors++; $display("FAIL reset_clear_pc got %0h exp 0", clear_pc); end
        repeat (3) dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (next_tag !== 5'd4) begin errors++; $display("FAIL reset_dispatch3 got %0d exp 4", next_tag); end
    endtask

    task automatic test_in_order();
        do_reset();
        repeat (3) dispatch(1'b1, 1'b0, 1'b0);
        set_alu(3, 32'd7, 1'b0, 32'h0);
        step();
        set_alu(1, 32'd5, 1'b0, 32'h0);
        step();
        alu_rdy = 1'b0;
        checks++; if (ROB_write_reg_rdy !== 1'b0) begin errors++; $display("FAIL order_early_commit got %0b exp 0", ROB_write_reg_rdy); end
        query_rs1_tag = 5'd2;
        query_rs2_tag = 5'd3;
        #1;
        checks++; if (ROB_rs1_valid !== 1'b0) begin errors++; $display("FAIL order_query_unready got %0b exp 0", ROB_rs1_valid); end
        checks++; if ({ROB_rs2_valid, ROB_rs2_ans_output} !== {1'b1, 32'd7}) begin errors++; $display("FAIL order_query_ready got %0b/%0h exp 1/7", ROB_rs2_valid, ROB_rs2_ans_output); end
        set_alu(2, 32'd6, 1'b0, 32'h0);
        step();
        alu_rdy = 1'b0;
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, 32'd5, 5'd2}) begin errors++; $display("FAIL order_commit1 got %0b/%0h/%0d exp 1/5/2", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, 32'd6, 5'd3}) begin errors++; $display("FAIL order_commit2 got %0b/%0h/%0d exp 1/6/3", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, 32'd7, 5'd4}) begin errors++; $display("FAIL order_commit3 got %0b/%0h/%0d exp 1/7/4", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_head_tag} !== {1'b0, 5'd4}) begin errors++; $display("FAIL order_idle got %0b/%0d exp 0/4", ROB_write_reg_rdy, ROB_head_tag); end
    endtask

    task automatic test_bypass();
        do_reset();
        repeat (2) dispatch(1'b1, 1'b0, 1'b0);
        set_alu(2, 32'hDEAD, 1'b0, 32'h0);
        query_rs1_tag = 5'd2;
        query_rs2_tag = 5'd0;
        #1;
        checks++; if ({ROB_rs1_valid, ROB_rs1_ans_output} !== {1'b1, 32'hDEAD}) begin errors++; $display("FAIL bypass_rs1 got %0b/%0h exp 1/dead", ROB_rs1_valid, ROB_rs1_ans_output); end
        checks++; if ({ROB_rs2_valid, ROB_rs2_ans_output} !== {1'b0, 32'h0}) begin errors++; $display("FAIL bypass_tag0 got %0b/%0h exp 0/0", ROB_rs2_valid, ROB_rs2_ans_output); end
        step();
        alu_rdy = 1'b0;
        #1;
        checks++; if ({ROB_rs1_valid, ROB_rs1_ans_output} !== {1'b1, 32'hDEAD}) begin errors++; $display("FAIL bypass_stored got %0b/%0h exp 1/dead", ROB_rs1_valid, ROB_rs1_ans_output); end
        checks++; if (ROB_write_reg_rdy !== 1'b0) begin errors++; $display("FAIL bypass_no_commit got %0b exp 0", ROB_write_reg_rdy); end
        set_alu(0, 32'h99, 1'b0, 32'h0);
        query_rs1_tag = 5'd0;
        #1;
        checks++; if (ROB_rs1_valid !== 1'b0) begin errors++; $display("FAIL bypass_alu_tag0 got %0b exp 0", ROB_rs1_valid); end
        set_alu(5, 32'h1234, 1'b0, 32'h0);
        query_rs2_tag = 5'd5;
        #1;
        checks++; if ({ROB_rs2_valid, ROB_rs2_ans_output} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL bypass_idle_tag got %0b/%0h exp 1/1234", ROB_rs2_valid, ROB_rs2_ans_output); end
        step();
        alu_rdy = 1'b0;
        #1;
        checks++; if (ROB_rs2_valid !== 1'b0) begin errors++; $display("FAIL bypass_nonbusy_wb got %0b exp 0", ROB_rs2_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        repeat (13) dispatch(1'b1, 1'b0, 1'b0);
        checks++; if ({ROB_FULL, next_tag} !== {1'b0, 5'd14}) begin errors++; $display("FAIL full_13 got %0b/%0d exp 0/14", ROB_FULL, next_tag); end
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if ({ROB_FULL, next_tag} !== {1'b1, 5'd15}) begin errors++; $display("FAIL full_14 got %0b/%0d exp 1/15", ROB_FULL, next_tag); end
        repeat (2) dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (next_tag !== 5'd1) begin errors++; $display("FAIL full_16_wrap got %0d exp 1", next_tag); end
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if ({ROB_FULL, next_tag} !== {1'b1, 5'd1}) begin errors++; $display("FAIL full_drop got %0b/%0d exp 1/1", ROB_FULL, next_tag); end
        // Write back tags in order; each one retires on the following edge.
        for (int k = 1; k <= ROB_SIZE; k++) begin
            set_alu(k, XLEN'(3 * k), 1'b0, 32'h0);
            step();
            if (k >= 2) begin
                checks++;
                if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, XLEN'(3 * (k - 1)), TAG_W'(k)}) begin
                    errors++;
                    $display("FAIL wrap_commit_%0d got %0b/%0d/%0d exp 1/%0d/%0d", k - 1, ROB_write_reg_rdy, ROB_write_val, ROB_head_tag, 3 * (k - 1), k);
                end
            end
        end
        alu_rdy = 1'b0;
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, 32'd48, 5'd1}) begin errors++; $display("FAIL wrap_commit_16 got %0b/%0d/%0d exp 1/48/1", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        checks++; if ({ROB_FULL, next_tag} !== {1'b0, 5'd1}) begin errors++; $display("FAIL wrap_empty got %0b/%0d exp 0/1", ROB_FULL, next_tag); end
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (next_tag !== 5'd2) begin errors++; $display("FAIL wrap_realloc got %0d exp 2", next_tag); end
    endtask

    task automatic test_mispredict();
        do_reset();
        dispatch(1'b0, 1'b1, 1'b1);
        dispatch(1'b0, 1'b1, 1'b0);
        dispatch(1'b1, 1'b0, 1'b0);
        set_alu(1, 32'h0, 1'b1, 32'h200);
        step();
        set_alu(2, 32'h0, 1'b1, 32'h100);
        step();
        checks++; if ({clear, ROB_head_tag} !== {1'b0, 5'd2}) begin errors++; $display("FAIL mp_correct_branch got %0b/%0d exp 0/2", clear, ROB_head_tag); end
        set_alu(3, 32'd33, 1'b0, 32'h0);
        step();
        checks++; if ({clear, clear_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL mp_clear got %0b/%0h exp 1/100", clear, clear_pc); end
        checks++; if ({next_tag, ROB_FULL, ROB_head_tag, ROB_write_reg_rdy} !== {5'd1, 1'b0, 5'd3, 1'b0}) begin errors++; $display("FAIL mp_flush got %0d/%0b/%0d/%0b exp 1/0/3/0", next_tag, ROB_FULL, ROB_head_tag, ROB_write_reg_rdy); end
        dispatch_rdy = 1'b1;
        set_alu(1, 32'd77, 1'b0, 32'h0);
        step();
        dispatch_rdy = 1'b0;
        alu_rdy      = 1'b0;
        query_rs1_tag = 5'd1;
        #1;
        checks++; if ({clear, clear_pc, next_tag} !== {1'b0, 32'h100, 5'd1}) begin errors++; $display("FAIL mp_after got %0b/%0h/%0d exp 0/100/1", clear, clear_pc, next_tag); end
        checks++; if (ROB_rs1_valid !== 1'b0) begin errors++; $display("FAIL mp_wb_ignored got %0b exp 0", ROB_rs1_valid); end
        repeat (13) dispatch(1'b1, 1'b0, 1'b0);
        checks++; if ({ROB_FULL, next_tag} !== {1'b0, 5'd14}) begin errors++; $display("FAIL mp_count_zero got %0b/%0d exp 0/14", ROB_FULL, next_tag); end
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (ROB_FULL !== 1'b1) begin errors++; $display("FAIL mp_count_full got %0b exp 1", ROB_FULL); end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        rdy_in = 1'b0;
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (next_tag !== 5'd1) begin errors++; $display("FAIL freeze_dispatch got %0d exp 1", next_tag); end
        rdy_in = 1'b1;
        dispatch(1'b1, 1'b0, 1'b0);
        checks++; if (next_tag !== 5'd2) begin errors++; $display("FAIL freeze_resume got %0d exp 2", next_tag); end
        rdy_in = 1'b0;
        set_alu(1, 32'd9, 1'b0, 32'h0);
        step();
        alu_rdy = 1'b0;
        query_rs1_tag = 5'd1;
        #1;
        checks++; if (ROB_rs1_valid !== 1'b0) begin errors++; $display("FAIL freeze_wb got %0b exp 0", ROB_rs1_valid); end
        rdy_in = 1'b1;
        set_alu(1, 32'd9, 1'b0, 32'h0);
        step();
        alu_rdy = 1'b0;
        rdy_in  = 1'b0;
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_head_tag} !== {1'b0, 5'd1}) begin errors++; $display("FAIL freeze_commit got %0b/%0d exp 0/1", ROB_write_reg_rdy, ROB_head_tag); end
        rdy_in = 1'b1;
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b1, 32'd9, 5'd2}) begin errors++; $display("FAIL freeze_release got %0b/%0d/%0d exp 1/9/2", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        rdy_in = 1'b0;
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, ROB_head_tag} !== {1'b0, 32'd9, 5'd2}) begin errors++; $display("FAIL freeze_hold got %0b/%0d/%0d exp 0/9/2", ROB_write_reg_rdy, ROB_write_val, ROB_head_tag); end
        rdy_in = 1'b1;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        repeat (6) dispatch(1'b1, 1'b0, 1'b0);
        set_alu(1, 32'h55, 1'b0, 32'h0);
        step();
        alu_rdy = 1'b0;
        step();
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, next_tag} !== {1'b1, 32'h55, 5'd7}) begin errors++; $display("FAIL midrst_pre got %0b/%0h/%0d exp 1/55/7", ROB_write_reg_rdy, ROB_write_val, next_tag); end
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if ({next_tag, ROB_head_tag, ROB_FULL} !== {5'd1, 5'd1, 1'b0}) begin errors++; $display("FAIL midrst_ptrs got %0d/%0d/%0b exp 1/1/0", next_tag, ROB_head_tag, ROB_FULL); end
        checks++; if ({ROB_write_reg_rdy, ROB_write_val, clear, clear_pc} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin errors++; $display("FAIL midrst_outs got %0b/%0h/%0b/%0h exp 0/0/0/0", ROB_write_reg_rdy, ROB_write_val, clear, clear_pc); end
        #3;
        rst_in = 1'b1;
        query_rs1_tag = 5'd2;
        #1;
        checks++; if (ROB_rs1_valid !== 1'b0) begin errors++; $display("FAIL midrst_entries got %0b exp 0", ROB_rs1_valid); end
        step();
        checks++; if ({ROB_write_reg_rdy, next_tag} !== {1'b0, 5'd1}) begin errors++; $display("FAIL midrst_after got %0b/%0d exp 0/1", ROB_write_reg_rdy, next_tag); end
    endtask

    initial begin
        idle_inputs();
        rst_in = 1'b0;
        test_reset();
        test_in_order();
        test_bypass();
        test_full_wrap();
        test_mispredict();
        test_rdy_freeze();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
